playback_controller: RTL and testbench



---
 rtl/playback_controller.sv | 172 +++++++++++++++++
 tb/tb_playback_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/playback_controller.sv
// Transport controller: maps play/pause, stop and fast-forward commands onto the
// Timer's count/reset/adder controls, pacing ticks with an internal prescaler.
module playback_controller #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned RAMP_TICKS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_pause,
    input  logic        stop,
    input  logic        ffwd,
    input  logic [11:0] track_len,
    output logic        timer_count,
    output logic        timer_reset,
    output logic [5:0]  timer_adder,
    output logic [1:0]  state,
    output logic [11:0] elapsed,
    output logic        track_done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = $clog2(RAMP_TICKS + 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FFWD  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    level_q, level_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [11:0]   elapsed_q, elapsed_d;
    logic          count_q, count_d;
    logic          treset_q, treset_d;
    logic [5:0]    adder_q, adder_d;
    logic          done_q, done_d;

    logic          running, overrun, tick, finish, do_stop, do_start;
    logic [11:0]   remaining, speed, step, elapsed_tick;

    always_comb begin
        running      = (state_q == ST_PLAY) || (state_q == ST_FFWD);
        overrun      = running && (elapsed_q >= track_len);
        tick         = running && !overrun && (presc_q == PW'(TICK_DIV - 1));
        remaining    = track_len - elapsed_q;
        if (state_q != ST_FFWD) begin
            speed = 12'd1;
        end else begin
            case (level_q)
                2'd0:    speed = 12'd1;
                2'd1:    speed = 12'd8;
                default: speed = 12'd15;
            endcase
        end
        step         = (remaining < speed) ? remaining : speed;
        elapsed_tick = elapsed_q + step;
        finish       = tick && (elapsed_tick == track_len);
        do_stop      = stop && (state_q != ST_STOP);
        do_start     = (state_q == ST_STOP) && play_pause && (track_len != 12'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_stop) begin
            state_d = ST_STOP;
        end else begin
            case (state_q)
                ST_STOP:  if (do_start) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (overrun || finish) state_d = ST_STOP;
                    else if (play_pause)   state_d = ST_PAUSE;
                    else if (ffwd)         state_d = ST_FFWD;
                end
                ST_PAUSE: if (play_pause) state_d = ST_PLAY;
                ST_FFWD: begin
                    if (overrun || finish) state_d = ST_STOP;
                    else if (play_pause)   state_d = ST_PAUSE;
                    else if (!ffwd)        state_d = ST_PLAY;
                end
                default:  state_d = ST_STOP;
            endcase
        end
    end

    always_comb begin
        presc_d   = presc_q;
        level_d   = level_q;
        ramp_d    = ramp_q;
        elapsed_d = elapsed_q;
        count_d   = 1'b0;
        treset_d  = 1'b0;
        adder_d   = adder_q;
        done_d    = 1'b0;
        if (do_stop || do_start) begin
            treset_d  = 1'b1;
            elapsed_d = '0;
            presc_d   = '0;
            level_d   = '0;
            ramp_d    = '0;
            adder_d   = 6'd1;
        end else begin
            if (running) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                count_d   = 1'b1;
                adder_d   = step[5:0];
                elapsed_d = elapsed_tick;
            end
            done_d = overrun || finish;
            // A tick strobe carries its own step; only an idle entry into PLAY restores 1.
            if (state_d == ST_PLAY && state_q != ST_PLAY && !tick) begin
                adder_d = 6'd1;
            end
            if (state_d != ST_FFWD) begin
                level_d = '0;
                ramp_d  = '0;
            end else if (state_q == ST_FFWD && tick) begin
                if (ramp_q == RW'(RAMP_TICKS - 1)) begin
                    ramp_d  = '0;
                    level_d = (level_q == 2'd2) ? 2'd2 : level_q + 2'd1;
                end else begin
                    ramp_d = ramp_q + RW'(1);
                end
            end
            if (state_d == ST_STOP) begin
                presc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            level_q   <= '0;
            ramp_q    <= '0;
            elapsed_q <= '0;
            count_q   <= 1'b0;
            treset_q  <= 1'b0;
            adder_q   <= 6'd1;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            level_q   <= level_d;
            ramp_q    <= ramp_d;
            elapsed_q <= elapsed_d;
            count_q   <= count_d;
            treset_q  <= treset_d;
            adder_q   <= adder_d;
            done_q    <= done_d;
        end
    end

    assign state       = state_q;
    assign elapsed     = elapsed_q;
    assign timer_count = count_q;
    assign timer_reset = treset_q;
    assign timer_adder = adder_q;
    assign track_done  = done_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller with TICK_DIV=4, RAMP_TICKS=3.
module tb_playback_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_pause = 1'b0;
    logic        stop = 1'b0;
    logic        ffwd = 1'b0;
    logic [11:0] track_len = 12'd200;
    logic        timer_count;
    logic        timer_reset;
    logic [5:0]  timer_adder;
    logic [1:0]  state;
    logic [11:0] elapsed;
    logic        track_done;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned sidx;
    int unsigned exp_seq [8] = '{1, 1, 1, 8, 8, 8, 15, 15};

    playback_controller #(.TICK_DIV(4), .RAMP_TICKS(3)) dut (
        .clk(clk), .reset(reset), .play_pause(play_pause), .stop(stop), .ffwd(ffwd),
        .track_len(track_len), .timer_count(timer_count), .timer_reset(timer_reset),
        .timer_adder(timer_adder), .state(state), .elapsed(elapsed), .track_done(track_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles expecting strobes when i%4==3; strobe adders follow exp_seq from sidx.
    task automatic run_strobes(input int unsigned n);
        for (int unsigned i = 1; i <= n; i++) begin
            cycle();
            check_eq("ff_count", {31'd0, timer_count}, (i % 4 == 3) ? 32'd1 : 32'd0);
            if (i % 4 == 3) begin
                check_eq("ff_adder", {26'd0, timer_adder}, exp_seq[sidx]);
                sidx++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"}, {30'd0, state}, 32'd0);
        check_eq({tag, "_elapsed"}, {20'd0, elapsed}, 32'd0);
        check_eq({tag, "_count"}, {31'd0, timer_count}, 32'd0);
        check_eq({tag, "_treset"}, {31'd0, timer_reset}, 32'd0);
        check_eq({tag, "_adder"}, {26'd0, timer_adder}, 32'd1);
        check_eq({tag, "_done"}, {31'd0, track_done}, 32'd0);
    endtask

    initial begin
        cycle();
        cycle();
        check_reset_vals("rst");
        reset = 1'b0;

        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        check_eq("start_state", {30'd0, state}, 32'd1);
        check_eq("start_treset", {31'd0, timer_reset}, 32'd1);
        for (int unsigned i = 1; i <= 12; i++) begin
            cycle();
            check_eq("play_count", {31'd0, timer_count}, (i % 4 == 0) ? 32'd1 : 32'd0);
            check_eq("play_treset", {31'd0, timer_reset}, 32'd0);
        end
        check_eq("play_elapsed", {20'd0, elapsed}, 32'd3);
        check_eq("play_adder", {26'd0, timer_adder}, 32'd1);

        cycle();
        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        check_eq("pause_state", {30'd0, state}, 32'd2);
        for (int unsigned i = 0; i < 40; i++) begin
            cycle();
            check_eq("pause_count", {31'd0, timer_count}, 32'd0);
        end
        check_eq("pause_elapsed", {20'd0, elapsed}, 32'd3);
        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        check_eq("resume_state", {30'd0, state}, 32'd1);
        check_eq("resume_count0", {31'd0, timer_count}, 32'd0);
        cycle();
        check_eq("resume_count1", {31'd0, timer_count}, 32'd0);
        cycle();
        check_eq("resume_strobe", {31'd0, timer_count}, 32'd1);
        check_eq("resume_elapsed", {20'd0, elapsed}, 32'd4);

        ffwd = 1'b1;
        cycle();
        check_eq("ff_state", {30'd0, state}, 32'd3);
        sidx = 0;
        run_strobes(31);
        check_eq("ff_elapsed", {20'd0, elapsed}, 32'd61);
        ffwd = 1'b0;
        cycle();
        check_eq("rel_state", {30'd0, state}, 32'd1);
        check_eq("rel_adder", {26'd0, timer_adder}, 32'd1);
        cycle();
        cycle();
        cycle();
        check_eq("rel_count", {31'd0, timer_count}, 32'd1);
        check_eq("rel_strobe_adder", {26'd0, timer_adder}, 32'd1);
        check_eq("rel_elapsed", {20'd0, elapsed}, 32'd62);

        ffwd = 1'b1;
        cycle();
        sidx = 0;
        run_strobes(27);
        check_eq("end_pre_elapsed", {20'd0, elapsed}, 32'd104);
        track_len = 12'd108;
        cycle();
        cycle();
        cycle();
        check_eq("end_pre_count", {31'd0, timer_count}, 32'd0);
        cycle();
        check_eq("end_count", {31'd0, timer_count}, 32'd1);
        check_eq("end_adder", {26'd0, timer_adder}, 32'd4);
        check_eq("end_elapsed", {20'd0, elapsed}, 32'd108);
        check_eq("end_done", {31'd0, track_done}, 32'd1);
        check_eq("end_state", {30'd0, state}, 32'd0);
        check_eq("end_treset", {31'd0, timer_reset}, 32'd0);
        for (int unsigned i = 0; i < 10; i++) begin
            cycle();
            check_eq("post_count", {31'd0, timer_count}, 32'd0);
            check_eq("post_treset", {31'd0, timer_reset}, 32'd0);
            check_eq("post_done", {31'd0, track_done}, 32'd0);
        end
        check_eq("post_elapsed", {20'd0, elapsed}, 32'd108);
        check_eq("post_state", {30'd0, state}, 32'd0);

        track_len = 12'd200;
        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        check_eq("restart_elapsed", {20'd0, elapsed}, 32'd0);
        check_eq("restart_treset", {31'd0, timer_reset}, 32'd1);
        ffwd = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) cycle();
        check_eq("h_count", {31'd0, timer_count}, 32'd1);
        check_eq("h_adder", {26'd0, timer_adder}, 32'd8);
        check_eq("h_elapsed", {20'd0, elapsed}, 32'd11);
        stop = 1'b1;
        play_pause = 1'b1;
        cycle();
        stop = 1'b0;
        play_pause = 1'b0;
        ffwd = 1'b0;
        check_eq("sp_state", {30'd0, state}, 32'd0);
        check_eq("sp_treset", {31'd0, timer_reset}, 32'd1);
        check_eq("sp_elapsed", {20'd0, elapsed}, 32'd0);
        check_eq("sp_count", {31'd0, timer_count}, 32'd0);
        check_eq("sp_adder", {26'd0, timer_adder}, 32'd1);
        cycle();
        check_eq("sp_treset_low", {31'd0, timer_reset}, 32'd0);

        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        ffwd = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) cycle();
        check_eq("lvl_clear_count", {31'd0, timer_count}, 32'd1);
        check_eq("lvl_clear_adder", {26'd0, timer_adder}, 32'd1);
        check_eq("lvl_clear_state", {30'd0, state}, 32'd3);
        ffwd = 1'b0;
        cycle();
        check_eq("j_state", {30'd0, state}, 32'd1);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check_reset_vals("midrst");
        reset = 1'b0;
        track_len = 12'd0;
        play_pause = 1'b1;
        cycle();
        play_pause = 1'b0;
        check_eq("zero_len_state", {30'd0, state}, 32'd0);
        check_eq("zero_len_treset", {31'd0, timer_reset}, 32'd0);
        cycle();
        check_eq("zero_len_state2", {30'd0, state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
